axis_operand_join: RTL and testbench



---
 rtl/axis_operand_join_pkg.sv | 15 +
 rtl/axis_hold_reg.sv | 50 +++++
 rtl/axis_operand_join.sv | 91 +++++++++
 tb/tb_axis_operand_join.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/axis_operand_join_pkg.sv
// Shared defaults for the AXI-Stream adder datapath (join stage, adder, output stage).
package axis_operand_join_pkg;

    // Operand width shared with the adder and the downstream output stage.
    localparam int unsigned DefWidth    = 4;
    // Default width of the emitted-pair counter.
    localparam int unsigned DefCntWidth = 16;

    // Occupancy of a single-entry holding register.
    typedef enum logic {
        StEmpty = 1'b0,
        StFull  = 1'b1
    } hold_state_e;

endpackage

// File: rtl/axis_hold_reg.sv
// Single-entry AXI-Stream holding register. Captures one beat and keeps it until
// release_i; a new beat may be reloaded in the same cycle as the release.
module axis_hold_reg
    import axis_operand_join_pkg::*;
#(
    parameter int unsigned DW = DefWidth + 1
) (
    input  logic          clk_i,
    input  logic          arstn_i,
    input  logic [DW-1:0] s_tdata_i,
    input  logic          s_tvalid_i,
    output logic          s_tready_o,
    input  logic          release_i,
    output logic          full_o,
    output logic [DW-1:0] data_o
);

    hold_state_e   state_q, state_d;
    logic [DW-1:0] data_q, data_d;
    logic          accept;

    // Ready/next-state: accept when empty, or when the held beat leaves this cycle.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        s_tready_o = arstn_i && ((state_q == StEmpty) || release_i);
        accept     = s_tvalid_i && s_tready_o;
        unique case (state_q)
            StEmpty: if (accept) state_d = StFull;
            StFull:  if (release_i) state_d = accept ? StFull : StEmpty;
            default: state_d = StEmpty;
        endcase
        if (accept) data_d = s_tdata_i;
    end

    // State and payload registers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= StEmpty;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign full_o = (state_q == StFull);
    assign data_o = data_q;

endmodule

// File: rtl/axis_operand_join.sv
// Joins operand A and B streams into one pair beat for the adder, with a sticky
// TLAST alignment check and a wrapping count of emitted pairs.
module axis_operand_join
    import axis_operand_join_pkg::*;
#(
    parameter int unsigned WIDTH     = DefWidth,
    parameter int unsigned CNT_WIDTH = DefCntWidth
) (
    input  logic                 clk_i,
    input  logic                 arstn_i,
    input  logic [WIDTH-1:0]     s_a_tdata_i,
    input  logic                 s_a_tvalid_i,
    input  logic                 s_a_tlast_i,
    output logic                 s_a_tready_o,
    input  logic [WIDTH-1:0]     s_b_tdata_i,
    input  logic                 s_b_tvalid_i,
    input  logic                 s_b_tlast_i,
    output logic                 s_b_tready_o,
    output logic [WIDTH-1:0]     m_data1_o,
    output logic [WIDTH-1:0]     m_data2_o,
    output logic                 m_tvalid_o,
    output logic                 m_tlast_o,
    input  logic                 m_tready_i,
    output logic                 last_err_o,
    output logic [CNT_WIDTH-1:0] pair_cnt_o
);

    logic             full_a, full_b;
    logic [WIDTH:0]   hold_a, hold_b;
    logic             pair_fire;
    logic             last_err_q, last_err_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // Payload is {tlast, tdata} so last travels with its operand.
    axis_hold_reg #(
        .DW (WIDTH + 1)
    ) u_hold_a (
        .clk_i      (clk_i),
        .arstn_i    (arstn_i),
        .s_tdata_i  ({s_a_tlast_i, s_a_tdata_i}),
        .s_tvalid_i (s_a_tvalid_i),
        .s_tready_o (s_a_tready_o),
        .release_i  (pair_fire),
        .full_o     (full_a),
        .data_o     (hold_a)
    );

    axis_hold_reg #(
        .DW (WIDTH + 1)
    ) u_hold_b (
        .clk_i      (clk_i),
        .arstn_i    (arstn_i),
        .s_tdata_i  ({s_b_tlast_i, s_b_tdata_i}),
        .s_tvalid_i (s_b_tvalid_i),
        .s_tready_o (s_b_tready_o),
        .release_i  (pair_fire),
        .full_o     (full_b),
        .data_o     (hold_b)
    );

    // Outputs come only from the holding registers; valid never looks at m_tready_i.
    assign m_tvalid_o = full_a && full_b;
    assign pair_fire  = m_tvalid_o && m_tready_i;
    assign m_data1_o  = hold_a[WIDTH-1:0];
    assign m_data2_o  = hold_b[WIDTH-1:0];
    assign m_tlast_o  = hold_a[WIDTH] | hold_b[WIDTH];
    assign last_err_o = last_err_q;
    assign pair_cnt_o = cnt_q;

    // Sticky TLAST mismatch and wrapping pair count, both updated on a fired pair.
    always_comb begin
        last_err_d = last_err_q;
        cnt_d      = cnt_q;
        if (pair_fire) begin
            cnt_d = cnt_q + 1'b1;
            if (hold_a[WIDTH] != hold_b[WIDTH]) last_err_d = 1'b1;
        end
    end

    // Status registers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            last_err_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            last_err_q <= last_err_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_axis_operand_join.sv
// Scoreboard bench: accepted beats are queued per channel; the monitor pairs them
// in arrival order and checks every cycle's outputs, readies, count and error flag.
module tb_axis_operand_join;

    localparam int unsigned W  = 4;
    localparam int unsigned CW = 2;

    typedef struct packed {
        logic [W-1:0] d;
        logic         l;
    } beat_t;

    logic          clk = 1'b0;
    logic          arstn = 1'b0;
    logic [W-1:0]  a_d = '0, b_d = '0;
    logic          a_v = 1'b0, a_l = 1'b0, b_v = 1'b0, b_l = 1'b0;
    logic          a_r, b_r;
    logic [W-1:0]  d1, d2;
    logic          m_v, m_l, m_r = 1'b0;
    logic          err;
    logic [CW-1:0] cnt;

    int total = 0;
    int bad = 0;

    beat_t qa[$];
    beat_t qb[$];
    int    exp_pairs = 0;
    logic  exp_err = 1'b0;
    logic  prev_stall = 1'b0;
    logic [W-1:0] prev_d1, prev_d2;
    logic  prev_l;

    axis_operand_join #(
        .WIDTH     (W),
        .CNT_WIDTH (CW)
    ) dut (
        .clk_i        (clk),
        .arstn_i      (arstn),
        .s_a_tdata_i  (a_d),
        .s_a_tvalid_i (a_v),
        .s_a_tlast_i  (a_l),
        .s_a_tready_o (a_r),
        .s_b_tdata_i  (b_d),
        .s_b_tvalid_i (b_v),
        .s_b_tlast_i  (b_l),
        .s_b_tready_o (b_r),
        .m_data1_o    (d1),
        .m_data2_o    (d2),
        .m_tvalid_o   (m_v),
        .m_tlast_o    (m_l),
        .m_tready_i   (m_r),
        .last_err_o   (err),
        .pair_cnt_o   (cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Record every handshake the DUT actually accepts.
    always @(posedge clk) begin
        if (arstn) begin
            if (a_v && a_r) qa.push_back('{d: a_d, l: a_l});
            if (b_v && b_r) qb.push_back('{d: b_d, l: b_l});
        end
    end

    // Monitor: pairs are the oldest accepted A with the oldest accepted B.
    always @(negedge clk) begin
        if (arstn) begin
            logic exp_v, fire;
            exp_v = (qa.size() > 0) && (qb.size() > 0);
            fire  = exp_v && m_r;
            chk("m_tvalid", m_v, exp_v);
            chk("pair_cnt", cnt, exp_pairs % (1 << CW));
            chk("last_err", err, exp_err);
            chk("a_tready", a_r, (qa.size() == 0) || fire);
            chk("b_tready", b_r, (qb.size() == 0) || fire);
            if (exp_v) begin
                chk("data1", d1, qa[0].d);
                chk("data2", d2, qb[0].d);
                chk("tlast", m_l, qa[0].l | qb[0].l);
            end
            if (prev_stall) begin
                chk("stall_data1", d1, prev_d1);
                chk("stall_data2", d2, prev_d2);
                chk("stall_tlast", m_l, prev_l);
            end
            prev_stall = exp_v && !m_r;
            prev_d1 = d1;
            prev_d2 = d2;
            prev_l  = m_l;
            if (fire) begin
                exp_pairs++;
                if (qa[0].l != qb[0].l) exp_err = 1'b1;
                void'(qa.pop_front());
                void'(qb.pop_front());
            end
        end
    end

    task automatic drive(input logic va, input logic [W-1:0] da, input logic la,
                         input logic vb, input logic [W-1:0] db, input logic lb,
                         input logic rdy);
        @(posedge clk);
        #1;
        a_v = va; a_d = da; a_l = la;
        b_v = vb; b_d = db; b_l = lb;
        m_r = rdy;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    endtask

    initial begin
        logic a_acc, b_acc;
        // Reset state.
        #2;
        chk("rst_m_tvalid", m_v, 0);
        chk("rst_data1", d1, 0);
        chk("rst_data2", d2, 0);
        chk("rst_tlast", m_l, 0);
        chk("rst_err", err, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_a_tready", a_r, 0);
        chk("rst_b_tready", b_r, 0);
        #19 arstn = 1'b1;

        // Simultaneous A=4/B=1.
        drive(1'b1, 4'd4, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1);
        idle(3);
        // A=9 runs ahead; a second A stays waiting while B is absent.
        drive(1'b1, 4'd9, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b1, 4'd7, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        drive(1'b1, 4'd7, 1'b0, 1'b1, 4'd3, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1, 4'd6, 1'b0, 1'b1);
        idle(3);
        // Back-to-back stream.
        drive(1'b1, 4'd4,  1'b0, 1'b1, 4'd1,  1'b0, 1'b1);
        drive(1'b1, 4'd9,  1'b0, 1'b1, 4'd3,  1'b0, 1'b1);
        drive(1'b1, 4'd13, 1'b0, 1'b1, 4'd13, 1'b0, 1'b1);
        drive(1'b1, 4'd5,  1'b0, 1'b1, 4'd2,  1'b0, 1'b1);
        idle(3);
        // Downstream stall holding (13,13).
        drive(1'b1, 4'd13, 1'b0, 1'b1, 4'd13, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        idle(3);
        // TLAST mismatch.
        drive(1'b1, 4'd2, 1'b1, 1'b1, 4'd2, 1'b0, 1'b1);
        idle(4);

        // Randomized traffic with AXI-correct source behaviour.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            a_acc = a_v && a_r;
            b_acc = b_v && b_r;
            #1;
            if (!a_v || a_acc) begin
                a_v = ($urandom_range(3) != 0);
                a_d = W'($urandom);
                a_l = ($urandom_range(7) == 0);
            end
            if (!b_v || b_acc) begin
                b_v = ($urandom_range(3) != 0);
                b_d = W'($urandom);
                b_l = ($urandom_range(7) == 0);
            end
            m_r = ($urandom_range(3) != 0);
        end

        // Fill both channels under stall, then reset mid-pair.
        drive(1'b1, 4'd11, 1'b1, 1'b1, 4'd12, 1'b1, 1'b0);
        drive(1'b1, 4'd11, 1'b1, 1'b1, 4'd12, 1'b1, 1'b0);
        drive(1'b1, 4'd11, 1'b1, 1'b1, 4'd12, 1'b1, 1'b0);
        #1 arstn = 1'b0;
        #1;
        chk("arst_m_tvalid", m_v, 0);
        chk("arst_data1", d1, 0);
        chk("arst_data2", d2, 0);
        chk("arst_tlast", m_l, 0);
        chk("arst_err", err, 0);
        chk("arst_cnt", cnt, 0);
        chk("arst_a_tready", a_r, 0);
        qa.delete();
        qb.delete();
        exp_pairs = 0;
        exp_err = 1'b0;
        prev_stall = 1'b0;
        a_v = 1'b0;
        b_v = 1'b0;
        m_r = 1'b1;
        @(posedge clk);
        #1 arstn = 1'b1;

        // Counter wrap 1,2,3,0,1 across five pairs after reset.
        for (int i = 0; i < 5; i++) drive(1'b1, W'(i), 1'b0, 1'b1, W'(i + 1), 1'b0, 1'b1);
        idle(2);
        chk("final_cnt", cnt, 1);
        chk("final_err", err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
